// File: rtl/rr_mux_arbiter.sv
// Four-lane round-robin arbiter feeding a 4:1 data mux into a one-entry
// registered output stage with valid/ready handshakes on both sides.
module rr_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       req_ready,
    output logic [1:0]       grant_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       last_grant
);

    logic [1:0]       start;
    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] data_p0;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic [1:0]       last_p1;

    function automatic logic [WIDTH-1:0] mux4(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] a0,
        input logic [WIDTH-1:0] a1,
        input logic [WIDTH-1:0] a2,
        input logic [WIDTH-1:0] a3
    );
        case (sel)
            2'b00:   mux4 = a0;
            2'b01:   mux4 = a1;
            2'b10:   mux4 = a2;
            default: mux4 = a3;
        endcase
    endfunction

    // Stage p0: rotating-priority search; scanning from the far end lets the
    // nearest requester after last_grant overwrite the others.
    always_comb begin
        start     = last_p1 + 2'd1;
        grant_sel = start;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[start + 2'(k)]) begin
                grant_sel = start + 2'(k);
            end
        end
    end

    assign accept    = !vld_p1 || out_ready;
    assign req_ready = (rst_n && accept && (|req_valid)) ? (4'b0001 << grant_sel) : 4'b0000;
    assign transfer  = |(req_valid & req_ready);
    assign data_p0   = mux4(grant_sel, d0, d1, d2, d3);

    // Stage p1: one-entry output register; drain and refill in the same cycle
    // keeps full throughput.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 2'b11;
        end else if (transfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_p0;
            last_p1 <= grant_sel;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_data   = data_p1;
    assign last_grant = last_p1;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed vector table followed by constrained
// random traffic compared against a behavioural round-robin model.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [7:0] dv [4];
    logic [3:0] req_ready;
    logic [1:0] grant_sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] last_grant;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit       m_valid = 0;
    bit [7:0] m_data = 0;
    int       m_last = 3;
    bit       last_xfer;
    int       last_g;

    typedef struct {
        logic       rst_n;
        logic [3:0] rv;
        logic       ordy;
        logic       chk_g;
        logic [3:0] ready;
        logic [1:0] grant;
        logic       valid;
        logic [7:0] data;
        logic [1:0] last;
    } vec_t;

    vec_t tab[$];

    rr_mux_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
        .req_ready(req_ready), .grant_sel(grant_sel),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .last_grant(last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(logic r, logic [3:0] rv, logic o, logic cg, logic [3:0] rdy,
                                 logic [1:0] g, logic v, logic [7:0] d, logic [1:0] l);
        vec_t t;
        t.rst_n = r; t.rv = rv; t.ordy = o; t.chk_g = cg; t.ready = rdy;
        t.grant = g; t.valid = v; t.data = d; t.last = l;
        return t;
    endfunction

    function automatic int model_grant(logic [3:0] rv, int last);
        for (int k = 1; k <= 4; k++) begin
            if (rv[(last + k) % 4]) return (last + k) % 4;
        end
        return (last + 1) % 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are already applied; check combinational outputs, clock once,
    // advance the model, then check registered outputs.
    task automatic tick(input bit use_tab, input vec_t v);
        int         g;
        logic [3:0] er;
        bit         xfer;
        logic [7:0] xd;
        g  = model_grant(req_valid, m_last);
        er = (rst_n && (!m_valid || out_ready) && req_valid != 4'b0) ? 4'(1 << g) : 4'b0;
        #1;
        if (use_tab) begin
            if (v.chk_g) chk("tab_grant_sel", 32'(grant_sel), 32'(v.grant));
            chk("tab_req_ready", 32'(req_ready), 32'(v.ready));
        end else begin
            chk("rnd_grant_sel", 32'(grant_sel), 32'(g));
            chk("rnd_req_ready", 32'(req_ready), 32'(er));
        end
        xfer = (er != 4'b0);
        xd   = dv[g];
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_last = 3;
        end else if (xfer) begin
            m_valid = 1; m_data = xd; m_last = g;
        end else if (out_ready) begin
            m_valid = 0;
        end
        last_xfer = xfer;
        last_g    = g;
        #1;
        if (use_tab) begin
            chk("tab_out_valid", 32'(out_valid), 32'(v.valid));
            chk("tab_out_data", 32'(out_data), 32'(v.data));
            chk("tab_last_grant", 32'(last_grant), 32'(v.last));
        end else begin
            chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd_out_data", 32'(out_data), 32'(m_data));
            chk("rnd_last_grant", 32'(last_grant), 32'(m_last));
        end
    endtask

    initial begin
        vec_t       dummy;
        logic [3:0] pend;
        int         waitc [4];

        rst_n = 1'b0; req_valid = 4'b0; out_ready = 1'b0;
        dv[0] = 8'h10; dv[1] = 8'hA5; dv[2] = 8'h30; dv[3] = 8'h40;

        //              rst  rv       ordy cg  ready    g  vld data  last
        tab.push_back(mkv(0, 4'b1111, 1, 0, 4'b0000, 0, 0, 8'h00, 3));
        tab.push_back(mkv(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 8'h00, 3));
        for (int i = 0; i < 8; i++)
            tab.push_back(mkv(1, 4'b1111, 1, 1, 4'(1 << (i % 4)), 2'(i % 4), 1,
                              (i % 4 == 0) ? 8'h10 : (i % 4 == 1) ? 8'hA5 : (i % 4 == 2) ? 8'h30 : 8'h40,
                              2'(i % 4)));
        tab.push_back(mkv(1, 4'b0010, 1, 1, 4'b0010, 1, 1, 8'hA5, 1));
        tab.push_back(mkv(1, 4'b0101, 1, 1, 4'b0100, 2, 1, 8'h30, 2));
        tab.push_back(mkv(1, 4'b0101, 1, 1, 4'b0001, 0, 1, 8'h10, 0));
        for (int i = 0; i < 3; i++)
            tab.push_back(mkv(1, 4'b0010, 0, 1, 4'b0000, 1, 1, 8'h10, 0));
        tab.push_back(mkv(1, 4'b0010, 1, 1, 4'b0010, 1, 1, 8'hA5, 1));
        tab.push_back(mkv(1, 4'b0000, 1, 1, 4'b0000, 2, 0, 8'hA5, 1));
        tab.push_back(mkv(1, 4'b0000, 0, 1, 4'b0000, 2, 0, 8'hA5, 1));
        for (int i = 0; i < 3; i++)
            tab.push_back(mkv(1, 4'b1000, 1, 1, 4'b1000, 3, 1, 8'h40, 3));
        tab.push_back(mkv(0, 4'b1111, 0, 1, 4'b0000, 0, 0, 8'h00, 3));
        tab.push_back(mkv(1, 4'b1111, 1, 1, 4'b0001, 0, 1, 8'h10, 0));

        foreach (tab[i]) begin
            rst_n = tab[i].rst_n; req_valid = tab[i].rv; out_ready = tab[i].ordy;
            tick(1, tab[i]);
        end

        // Random traffic: a lane holds valid and data until accepted.
        dummy = tab[0];
        pend = 4'b0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    dv[i] = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        waitc[i] = 0;
                    end
                end
            end
            req_valid = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick(0, dummy);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) waitc[i] = 0;
            end else if (last_xfer) begin
                chk("fairness_wait", 32'(waitc[last_g] <= 3), 32'd1);
                pend[last_g] = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (pend[i] && i != last_g) waitc[i]++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Four-requester round-robin arbiter that shares a single WIDTH-bit output channel.
- Internally it drives the select of a 4:1 data multiplexer (mux_2s-style, select encoding 00→d0 … 11→d3) and registers the winning word into a one-entry output stage.
- Valid/ready handshake on every input and on the output; sits between producer lanes and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester lane and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  4  bit i = requester i presents valid data on d<i>.
- d0  input  WIDTH  requester 0 data.
- d1  input  WIDTH  requester 1 data.
- d2  input  WIDTH  requester 2 data.
- d3  input  WIDTH  requester 3 data.
- req_ready  output  4  one-hot (or zero) accept to requesters; combinational.
- grant_sel  output  2  current winning index driving the mux select; combinational.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  output register contents.
- out_ready  input  1  consumer accepts the word this cycle.
- last_grant  output  2  index of the most recently accepted requester (registered).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, last_grant=2'b11 (so requester 0 has first priority).
  - Inputs are ignored during reset; req_ready=0 while rst_n=0.
- accept = !out_valid || out_ready (one-entry pipeline; full throughput when the consumer is always ready).
- Arbitration (combinational):
  - Search order starts at last_grant+1 (mod 4) and wraps: e.g. last_grant=2 → order 3,0,1,2.
  - grant_sel = first index in that order with req_valid set.
  - If no req_valid, grant_sel = last_grant+1 (mod 4). It is don't-care for the data path but must be deterministic.
- Handshake:
  - req_ready[grant_sel] = accept && |req_valid; all other req_ready bits = 0.
  - A transfer occurs on input i when req_valid[i] && req_ready[i].
- On a transfer at an edge:
  - out_data <= mux(d0..d3, grant_sel), out_valid <= 1, last_grant <= grant_sel.
  - Latency is 1 cycle from input handshake to out_valid.
- Output drain: if out_valid && out_ready and there is no new transfer, out_valid <= 0 and out_data holds its value.
- Simultaneous drain + transfer: out_valid stays 1 and out_data is replaced with no bubble.
- Stall: if out_valid && !out_ready, all req_ready=0 and out_data/out_valid/last_grant hold. This stall is required behaviour.
- Requesters must hold req_valid/data until accepted. The arbiter does not lock grant across stalls: grant is re-evaluated each cycle from last_grant and current req_valid.
- Fairness: a continuously requesting lane is served within 4 accepted transfers.
- Reset mid-operation: the pending output word is discarded (out_valid=0) and priority returns to requester 0.
- No X propagation: out_data changes only on a transfer or reset.

Test Plan:
- Reset then all req_valid=4'b1111, out_ready=1 held 8 cycles → transfers in order 0,1,2,3,0,1,2,3; out_data sequence matches d0..d3 one cycle after each req_ready pulse; out_valid=1 continuously after the first cycle.
- last_grant=1, req_valid=4'b0101 → grant_sel=2 and req_ready=4'b0100; next cycle with the same request → grant_sel=0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=4'b0010, d1=8'hA5 → req_ready=0 and out_data holds the prior value. Release out_ready → the same cycle req_ready=4'b0010, and the next cycle out_data=8'hA5.
- Drain with no requests: out_valid=1, out_ready=1, req_valid=0 → out_valid=0 next cycle and out_data unchanged.
- Single requester 3 streaming (req_valid=4'b1000, out_ready=1) → accepted every cycle, last_grant stays 3, no bubbles.
- Assert rst_n=0 for one edge while out_valid=1 → out_valid=0, out_data=0, last_grant=3; with all requesting afterwards, the first grant is 0.
